// File: rtl/line_buf_sequencer.sv
// Pixel/line sequencer for the row-RAM window datapath; optional LB_SEQ_STATS_EN adds a frame counter.
// Latency: RAM controls same cycle as the pixel; win_valid/frame_done one cycle later.
// Backpressure: none, every qualified pixel is consumed; IDLE drops pixels until sof.
module line_buf_sequencer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int AW     = 10,
    parameter int KSIZE  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    input  logic             sof,
    input  logic             eol,
    output logic [KSIZE-2:0] row_wr_en,
    output logic [AW-1:0]    wr_adr,
    output logic [AW-1:0]    rd_adr,
    output logic             win_valid,
    output logic             frame_done,
    output logic             line_err,
    output logic [1:0]       state,
    output logic [15:0]      frame_cnt
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] WIN_COL  = CW'(KSIZE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [RW-1:0] ROW_FILL = RW'(KSIZE - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          line_err_q, line_err_d;
    logic          win_valid_q, win_valid_d;
    logic          frame_done_q, frame_done_d;

    logic accept;
    logic resync;
    logic col_last;
    logic line_end;
    logic line_bad;
    logic last_row;
    logic fill_done;

    // Nothing is accepted while reset is held, so RAM controls stay quiet during reset.
    always_comb begin
        accept    = pix_valid & ~rst & ((state_q != S_IDLE) | sof);
        resync    = accept & sof;
        col_last  = (col_q == COL_LAST);
        line_end  = accept & ~sof & (eol | col_last);
        line_bad  = line_end & (eol ^ col_last);
        last_row  = (row_q == ROW_LAST);
        fill_done = (row_q == ROW_FILL);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (resync) begin
            state_d = S_FILL;
        end else if (line_end) begin
            case (state_q)
                S_FILL:  if (fill_done) state_d = S_RUN;
                S_RUN:   if (last_row)  state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // FSM outputs: RAM controls for the current pixel and next-cycle flags
    always_comb begin
        row_wr_en    = {(KSIZE-1){accept}};
        wr_adr       = AW'(col_q);
        rd_adr       = col_last ? '0 : AW'(col_q + CW'(1));
        win_valid_d  = accept & (state_q == S_RUN) & (col_q >= WIN_COL);
        frame_done_d = line_end & (state_q == S_RUN) & last_row;
    end

    // Early eol and overflow both close the line; only the error flag distinguishes them.
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        line_err_d = line_err_q;
        if (resync) begin
            col_d      = CW'(1);
            row_d      = '0;
            line_err_d = 1'b0;
        end else if (line_end) begin
            col_d      = '0;
            row_d      = frame_done_d ? '0 : row_q + RW'(1);
            line_err_d = line_err_q | line_bad;
        end else if (accept) begin
            col_d = col_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            line_err_q   <= 1'b0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            line_err_q   <= line_err_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef LB_SEQ_STATS_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (frame_done_d) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
    assign line_err   = line_err_q;
    assign state      = state_q;

endmodule

// File: tb/tb_line_buf_sequencer.sv
// Directed bench for line_buf_sequencer with an 8x4 frame and a 3x3 window.
module tb_line_buf_sequencer;

    localparam int W = 8;
    localparam int H = 4;
    localparam int K = 3;
    localparam int A = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         pix_valid;
    logic         sof;
    logic         eol;
    logic [K-2:0] row_wr_en;
    logic [A-1:0] wr_adr;
    logic [A-1:0] rd_adr;
    logic         win_valid;
    logic         frame_done;
    logic         line_err;
    logic [1:0]   state;
    logic [15:0]  frame_cnt;

    int checks = 0;
    int errors = 0;
    int cur_idx = -1;
    int pidx = 0;
    int wv_cnt = 0;
    int first_wv = -1;
    int fd_cnt = 0;

    line_buf_sequencer #(.WIDTH(W), .HEIGHT(H), .AW(A), .KSIZE(K)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .eol        (eol),
        .row_wr_en  (row_wr_en),
        .wr_adr     (wr_adr),
        .rd_adr     (rd_adr),
        .win_valid  (win_valid),
        .frame_done (frame_done),
        .line_err   (line_err),
        .state      (state),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    // Registered flags seen at a falling edge belong to the pixel tagged in cur_idx.
    always @(negedge clk) begin
        if (win_valid === 1'b1) begin
            if (first_wv < 0) first_wv = cur_idx;
            wv_cnt++;
        end
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic px(input logic s, input logic e);
        @(negedge clk);
        pix_valid = 1'b1;
        sof       = s;
        eol       = e;
        #1;
        cur_idx = pidx;
        pidx++;
    endtask

    task automatic idle();
        @(negedge clk);
        pix_valid = 1'b0;
        sof       = 1'b0;
        eol       = 1'b0;
        #1;
        cur_idx = -1;
    endtask

    task automatic clr_mon();
        wv_cnt   = 0;
        first_wv = -1;
        fd_cnt   = 0;
        pidx     = 0;
    endtask

    task automatic test_reset();
        logic [25:0] obs;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pix_valid = i[0];
            sof       = i[1];
            eol       = 1'b1;
            #1;
            obs = {row_wr_en, wr_adr, rd_adr, win_valid, frame_done, line_err, state, frame_cnt};
            checks++;
            if (obs !== {2'b00, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0}) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %h expected %h", i, obs,
                         {2'b00, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        pix_valid = 1'b1;
        sof = 1'b0;
        eol = 1'b0;
        #1;
        checks++;
        if (row_wr_en !== 2'b00) begin
            errors++;
            $display("FAIL idle_drop_wr_en: got %b expected 00", row_wr_en);
        end
        idle();
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL idle_drop_state: got %0d expected 0", state);
        end
    endtask

    task automatic test_full_frame();
        idle();
        clr_mon();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                px(r == 0 && c == 0, c == W - 1);
                if (r == 0 && c == 1) begin
                    checks++;
                    if (state !== 2'd1) begin
                        errors++;
                        $display("FAIL frame_fill_state: got %0d expected 1", state);
                    end
                end
                if (r == 2 && c == 0) begin
                    checks++;
                    if (state !== 2'd2) begin
                        errors++;
                        $display("FAIL frame_run_state: got %0d expected 2", state);
                    end
                end
            end
        end
        idle();
        checks++;
        if (frame_done !== 1'b1 || state !== 2'd0) begin
            errors++;
            $display("FAIL frame_done_pulse: got done=%b state=%0d expected done=1 state=0",
                     frame_done, state);
        end
        idle();
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_width: got %b expected 0", frame_done);
        end
        checks++;
        if (wv_cnt !== 12) begin
            errors++;
            $display("FAIL frame_win_count: got %0d expected 12", wv_cnt);
        end
        checks++;
        if (first_wv !== 18) begin
            errors++;
            $display("FAIL frame_first_win: got pixel %0d expected 18", first_wv);
        end
        checks++;
        if (fd_cnt !== 1) begin
            errors++;
            $display("FAIL frame_done_count: got %0d expected 1", fd_cnt);
        end
    endtask

    task automatic test_wrap();
        idle();
        px(1'b1, 1'b0);
        for (int c = 1; c < W - 1; c++) begin
            px(1'b0, 1'b0);
            if (c == 3) begin
                checks++;
                if (wr_adr !== 3'd3 || rd_adr !== 3'd4) begin
                    errors++;
                    $display("FAIL wrap_mid: got wr=%0d rd=%0d expected wr=3 rd=4", wr_adr, rd_adr);
                end
            end
        end
        px(1'b0, 1'b1);
        checks++;
        if (wr_adr !== 3'd7 || rd_adr !== 3'd0) begin
            errors++;
            $display("FAIL wrap_last: got wr=%0d rd=%0d expected wr=7 rd=0", wr_adr, rd_adr);
        end
        px(1'b0, 1'b0);
        checks++;
        if (wr_adr !== 3'd0 || rd_adr !== 3'd1) begin
            errors++;
            $display("FAIL wrap_next: got wr=%0d rd=%0d expected wr=0 rd=1", wr_adr, rd_adr);
        end
    endtask

    task automatic test_early_eol();
        idle();
        for (int c = 0; c < W; c++) px(c == 0, c == W - 1);
        for (int c = 0; c < 5; c++) px(1'b0, 1'b0);
        px(1'b0, 1'b1);
        checks++;
        if (line_err !== 1'b0) begin
            errors++;
            $display("FAIL early_eol_pre: got line_err=%b expected 0", line_err);
        end
        px(1'b0, 1'b0);
        checks++;
        if (line_err !== 1'b1 || wr_adr !== 3'd0 || state !== 2'd2) begin
            errors++;
            $display("FAIL early_eol: got err=%b wr=%0d state=%0d expected err=1 wr=0 state=2",
                     line_err, wr_adr, state);
        end
        px(1'b1, 1'b0);
        checks++;
        if (line_err !== 1'b1) begin
            errors++;
            $display("FAIL early_eol_sticky: got %b expected 1", line_err);
        end
        px(1'b0, 1'b0);
        checks++;
        if (line_err !== 1'b0 || wr_adr !== 3'd1) begin
            errors++;
            $display("FAIL early_eol_clear: got err=%b wr=%0d expected err=0 wr=1", line_err, wr_adr);
        end
    endtask

    task automatic test_overflow();
        idle();
        px(1'b1, 1'b0);
        for (int c = 1; c < W; c++) px(1'b0, 1'b0);
        checks++;
        if (line_err !== 1'b0 || wr_adr !== 3'd7) begin
            errors++;
            $display("FAIL overflow_8th: got err=%b wr=%0d expected err=0 wr=7", line_err, wr_adr);
        end
        px(1'b0, 1'b0);
        checks++;
        if (line_err !== 1'b1 || wr_adr !== 3'd0) begin
            errors++;
            $display("FAIL overflow_9th: got err=%b wr=%0d expected err=1 wr=0", line_err, wr_adr);
        end
        px(1'b0, 1'b0);
        checks++;
        if (wr_adr !== 3'd1 || state !== 2'd1) begin
            errors++;
            $display("FAIL overflow_10th: got wr=%0d state=%0d expected wr=1 state=1", wr_adr, state);
        end
    endtask

    task automatic test_sof_mid_run();
        idle();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < W; c++) px(r == 0 && c == 0, c == W - 1);
        px(1'b0, 1'b0);
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL midrun_pre_state: got %0d expected 2", state);
        end
        clr_mon();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                px(r == 0 && c == 0, c == W - 1);
                if (r == 0 && c == 1) begin
                    checks++;
                    if (state !== 2'd1) begin
                        errors++;
                        $display("FAIL midrun_resync_state: got %0d expected 1", state);
                    end
                end
            end
        end
        idle();
        idle();
        checks++;
        if (wv_cnt !== 12 || first_wv !== 18) begin
            errors++;
            $display("FAIL midrun_windows: got count=%0d first=%0d expected count=12 first=18",
                     wv_cnt, first_wv);
        end
    endtask

    task automatic test_rst_mid_line();
        idle();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < W; c++) px(r == 0 && c == 0, c == W - 1);
        for (int c = 0; c < 5; c++) px(1'b0, 1'b0);
        checks++;
        if (win_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_win: got %b expected 1", win_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({win_valid, state, row_wr_en, wr_adr, rd_adr} !== {1'b0, 2'd0, 2'b00, 3'd0, 3'd1}) begin
            errors++;
            $display("FAIL rst_async: got win=%b state=%0d en=%b wr=%0d rd=%0d expected 0 0 00 0 1",
                     win_valid, state, row_wr_en, wr_adr, rd_adr);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        clr_mon();
        for (int c = 0; c < 3; c++) px(1'b0, 1'b0);
        idle();
        checks++;
        if (wv_cnt !== 0 || state !== 2'd0) begin
            errors++;
            $display("FAIL rst_release: got wins=%0d state=%0d expected wins=0 state=0", wv_cnt, state);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_cnt;
`ifdef LB_SEQ_STATS_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle();
        clr_mon();
        for (int f = 0; f < 3; f++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) px(r == 0 && c == 0, c == W - 1);
        idle();
        idle();
        checks++;
        if (fd_cnt !== 3 || wv_cnt !== 36) begin
            errors++;
            $display("FAIL b2b_counts: got done=%0d wins=%0d expected done=3 wins=36", fd_cnt, wv_cnt);
        end
        checks++;
        if (frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL frame_cnt: got %0d expected %0d", frame_cnt, exp_cnt);
        end
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL b2b_state: got %0d expected 0", state);
        end
    endtask

    initial begin
        rst       = 1'b1;
        pix_valid = 1'b0;
        sof       = 1'b0;
        eol       = 1'b0;
        test_reset();
        test_full_frame();
        test_wrap();
        test_early_eol();
        test_overflow();
        test_sof_mid_run();
        test_rst_mid_line();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
